// File: rtl/gps_sig_gen_if.sv
// Control, navigation-data and sample signals of the synthetic GPS L1 C/A source.
// The controller or testbench drives the master side and the generator takes the slave side.
interface gps_sig_gen_if;
    logic               start;
    logic               stop;
    logic [5:0]         prn;
    logic [9:0]         code_phase_init;
    logic signed [15:0] doppler_omega;
    logic               nav_en;
    logic               nav_bit;
    logic               nav_req;
    logic               adc_clk;
    logic               i_sample;
    logic               q_sample;
    logic               epoch;
    logic [9:0]         chip_count;
    logic               busy;
    logic               err;

    modport master (
        output start, stop, prn, code_phase_init, doppler_omega, nav_en, nav_bit,
        input  nav_req, adc_clk, i_sample, q_sample, epoch, chip_count, busy, err
    );

    modport slave (
        input  start, stop, prn, code_phase_init, doppler_omega, nav_en, nav_bit,
        output nav_req, adc_clk, i_sample, q_sample, epoch, chip_count, busy, err
    );
endinterface

// File: rtl/gps_sig_gen.sv
// Synthetic GPS L1 C/A baseband source: one Gold-code PRN with a code NCO, a Doppler LO
// and optional nav-data modulation, emitting 1-bit I/Q on an adc_clk strobe.
module gps_sig_gen #(
    parameter int unsigned CODE_NCO_OMEGA = 67027,
    parameter int unsigned SAMPLE_DIV     = 4,
    parameter int unsigned EPOCHS_PER_BIT = 20
) (
    input logic          clk,
    input logic          rst,
    gps_sig_gen_if.slave bus
);
    localparam int DIV_W   = $clog2(SAMPLE_DIV);
    localparam int EPOCH_W = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HALF   = DIV_W'(SAMPLE_DIV / 2);
    localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCHS_PER_BIT - 1);
    localparam logic [9:0]         LAST_CHIP  = 10'd1022;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t             state;
    logic [10:1]        g1, g2, taps;
    logic [10:1]        g1_adv, g2_adv;
    logic [9:0]         slew;
    logic [17:0]        code_acc, code_sum;
    logic               code_carry;
    logic [15:0]        phase, dop;
    logic [DIV_W-1:0]   div;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic               data_bit, nav_en_l;
    logic               chip, s;
    logic               prn_ok;

    // G2 tap pair per PRN, returned as a two-hot mask over G2[10:1].
    function automatic logic [10:1] tap_mask(input logic [5:0] p);
        logic [3:0] t1, t2;
        case (p)
            6'd1:    begin t1 = 4'd2; t2 = 4'd6;  end
            6'd2:    begin t1 = 4'd3; t2 = 4'd7;  end
            6'd3:    begin t1 = 4'd4; t2 = 4'd8;  end
            6'd4:    begin t1 = 4'd5; t2 = 4'd9;  end
            6'd5:    begin t1 = 4'd1; t2 = 4'd9;  end
            6'd6:    begin t1 = 4'd2; t2 = 4'd10; end
            6'd7:    begin t1 = 4'd1; t2 = 4'd8;  end
            6'd8:    begin t1 = 4'd2; t2 = 4'd9;  end
            6'd9:    begin t1 = 4'd3; t2 = 4'd10; end
            6'd10:   begin t1 = 4'd2; t2 = 4'd3;  end
            6'd11:   begin t1 = 4'd3; t2 = 4'd4;  end
            6'd12:   begin t1 = 4'd5; t2 = 4'd6;  end
            6'd13:   begin t1 = 4'd6; t2 = 4'd7;  end
            6'd14:   begin t1 = 4'd7; t2 = 4'd8;  end
            6'd15:   begin t1 = 4'd8; t2 = 4'd9;  end
            6'd16:   begin t1 = 4'd9; t2 = 4'd10; end
            6'd17:   begin t1 = 4'd1; t2 = 4'd4;  end
            6'd18:   begin t1 = 4'd2; t2 = 4'd5;  end
            6'd19:   begin t1 = 4'd3; t2 = 4'd6;  end
            6'd20:   begin t1 = 4'd4; t2 = 4'd7;  end
            6'd21:   begin t1 = 4'd5; t2 = 4'd8;  end
            6'd22:   begin t1 = 4'd6; t2 = 4'd9;  end
            6'd23:   begin t1 = 4'd1; t2 = 4'd3;  end
            6'd24:   begin t1 = 4'd4; t2 = 4'd6;  end
            6'd25:   begin t1 = 4'd5; t2 = 4'd7;  end
            6'd26:   begin t1 = 4'd6; t2 = 4'd8;  end
            6'd27:   begin t1 = 4'd7; t2 = 4'd9;  end
            6'd28:   begin t1 = 4'd8; t2 = 4'd10; end
            6'd29:   begin t1 = 4'd1; t2 = 4'd6;  end
            6'd30:   begin t1 = 4'd2; t2 = 4'd7;  end
            6'd31:   begin t1 = 4'd3; t2 = 4'd8;  end
            6'd32:   begin t1 = 4'd4; t2 = 4'd9;  end
            default: begin t1 = 4'd2; t2 = 4'd6;  end
        endcase
        return (10'b1 << (t1 - 4'd1)) | (10'b1 << (t2 - 4'd1));
    endfunction

    always_comb begin
        g1_adv                 = {g1[9:1], g1[3] ^ g1[10]};
        g2_adv                 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
        chip                   = g1[10] ^ (^(g2 & taps));
        s                      = chip ^ (data_bit & nav_en_l);
        {code_carry, code_sum} = {1'b0, code_acc} + 19'(CODE_NCO_OMEGA);
        prn_ok                 = (bus.prn != 6'd0) && (bus.prn <= 6'd32);
    end

    // Stop shares the reset path for the outputs but leaves the channel setup untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            g1             <= '1;
            g2             <= '1;
            taps           <= '0;
            slew           <= '0;
            code_acc       <= '0;
            phase          <= '0;
            dop            <= '0;
            div            <= '0;
            epoch_cnt      <= '0;
            data_bit       <= 1'b0;
            nav_en_l       <= 1'b0;
            bus.adc_clk    <= 1'b0;
            bus.i_sample   <= 1'b0;
            bus.q_sample   <= 1'b0;
            bus.epoch      <= 1'b0;
            bus.nav_req    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
            bus.chip_count <= '0;
        end else begin
            bus.epoch   <= 1'b0;
            bus.nav_req <= 1'b0;
            bus.err     <= 1'b0;
            if (bus.stop) begin
                state          <= IDLE;
                bus.busy       <= 1'b0;
                bus.adc_clk    <= 1'b0;
                bus.i_sample   <= 1'b0;
                bus.q_sample   <= 1'b0;
                bus.chip_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && prn_ok) begin
                            state          <= LOAD;
                            bus.busy       <= 1'b1;
                            g1             <= '1;
                            g2             <= '1;
                            taps           <= tap_mask(bus.prn);
                            slew           <= (bus.code_phase_init > LAST_CHIP) ? LAST_CHIP
                                                                                : bus.code_phase_init;
                            bus.chip_count <= '0;
                            code_acc       <= '0;
                            phase          <= '0;
                            dop            <= bus.doppler_omega;
                            div            <= '0;
                            epoch_cnt      <= '0;
                            data_bit       <= 1'b0;
                            nav_en_l       <= bus.nav_en;
                        end else if (bus.start) begin
                            bus.err <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (slew != 10'd0) begin
                            g1             <= g1_adv;
                            g2             <= g2_adv;
                            bus.chip_count <= bus.chip_count + 10'd1;
                            slew           <= slew - 10'd1;
                        end
                        if (slew <= 10'd1) state <= RUN;
                    end
                    RUN: begin
                        div         <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
                        bus.adc_clk <= (div < DIV_HALF);
                        // LO quadrants (phase[15:14]) give I = 0,0,1,1 and Q = 0,1,1,0.
                        if (div == '0) begin
                            bus.i_sample <= s ^ phase[15];
                            bus.q_sample <= s ^ phase[15] ^ phase[14];
                            code_acc     <= code_sum;
                            phase        <= phase + dop;
                            if (code_carry && (bus.chip_count == LAST_CHIP)) begin
                                g1             <= '1;
                                g2             <= '1;
                                bus.chip_count <= '0;
                                bus.epoch      <= 1'b1;
                                if (epoch_cnt == EPOCH_LAST) begin
                                    epoch_cnt   <= '0;
                                    bus.nav_req <= 1'b1;
                                    data_bit    <= bus.nav_bit & nav_en_l;
                                end else begin
                                    epoch_cnt <= epoch_cnt + EPOCH_W'(1);
                                end
                            end else if (code_carry) begin
                                g1             <= g1_adv;
                                g2             <= g2_adv;
                                bus.chip_count <= bus.chip_count + 10'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gps_sig_gen.sv
// Directed bench for gps_sig_gen: PRN code sequences, code-phase slew, epoch and nav-bit
// timing, Doppler LO rotation, start rejection, stop and mid-run reset.
module tb_gps_sig_gen;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    gps_sig_gen_if bus ();

    gps_sig_gen #(
        .CODE_NCO_OMEGA(131072),
        .SAMPLE_DIV    (4),
        .EPOCHS_PER_BIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic       adc_prev;
    logic       smp_i, smp_q, smp_epoch, smp_nreq, smp_ok;
    logic [9:0] smp_chip;
    int         smp_wait;

    // First ten PRN1 / PRN2 chips, and the same chips held for two samples each.
    logic [9:0]  prn1_chips  = 10'b1100100000;
    logic [19:0] prn1_pat    = 20'b1111_0000_1100_0000_0000;
    logic [19:0] prn2_pat    = 20'b1111_1100_0011_0000_0000;
    logic [1:0]  exp_dop [16] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10,
                                  2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};

    function automatic logic [16:0] out_vec();
        return {bus.adc_clk, bus.i_sample, bus.q_sample, bus.epoch, bus.nav_req,
                bus.busy, bus.err, bus.chip_count};
    endfunction

    // Waits (bounded) for the next adc_clk rise and captures the registered outputs there.
    task automatic next_sample();
        smp_ok   = 1'b0;
        smp_wait = 0;
        while (!smp_ok && smp_wait < 1200) begin
            @(negedge clk);
            smp_wait++;
            if (bus.adc_clk && !adc_prev) begin
                smp_ok    = 1'b1;
                smp_i     = bus.i_sample;
                smp_q     = bus.q_sample;
                smp_epoch = bus.epoch;
                smp_nreq  = bus.nav_req;
                smp_chip  = bus.chip_count;
            end
            adc_prev = bus.adc_clk;
        end
        if (!smp_ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL sample_timeout: no adc_clk rise within %0d cycles", smp_wait);
        end
    endtask

    task automatic pulse_start(input logic [5:0] p, input logic [9:0] init,
                               input logic [15:0] dop, input logic ne);
        @(negedge clk);
        bus.prn             = p;
        bus.code_phase_init = init;
        bus.doppler_omega   = dop;
        bus.nav_en          = ne;
        bus.start           = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        adc_prev  = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (out_vec() !== 17'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", out_vec());
        end
        rst = 1'b1;
    endtask

    task automatic test_prn1_sequence();
        logic c;
        pulse_start(6'd1, 10'd0, 16'd0, 1'b0);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL busy_rise: got %b expected 1", bus.busy);
        end
        for (int k = 0; k < 20; k++) begin
            next_sample();
            if (!smp_ok) break;
            if (k == 0) begin
                tests++;
                if (smp_wait != 2) begin
                    fails++;
                    $display("[TB] FAIL load0_latency: got %0d cycles expected 2", smp_wait);
                end
            end
            if (k == 1) begin
                tests++;
                if (smp_wait != 4) begin
                    fails++;
                    $display("[TB] FAIL sample_period: got %0d cycles expected 4", smp_wait);
                end
            end
            c = prn1_chips[4'(9 - k / 2)];
            tests++;
            if ({smp_i, smp_q} !== {c, c}) begin
                fails++;
                $display("[TB] FAIL prn1_sample%0d: got %b%b expected %b%b", k, smp_i, smp_q, c, c);
            end
        end
        do_stop();
    endtask

    task automatic test_prn2_sequence();
        logic [19:0] obs;
        obs = '0;
        pulse_start(6'd2, 10'd0, 16'd0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            next_sample();
            obs = {obs[18:0], smp_i & smp_q};
        end
        tests++;
        if (obs !== prn2_pat) begin
            fails++;
            $display("[TB] FAIL prn2_chips: got %b expected %b", obs, prn2_pat);
        end
        do_stop();
    endtask

    task automatic test_code_phase();
        pulse_start(6'd1, 10'd3, 16'd0, 1'b0);
        next_sample();
        tests++;
        if (smp_wait != 4 || smp_chip !== 10'd3 || {smp_i, smp_q} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL code_phase3: got wait=%0d chip=%0d iq=%b%b expected wait=4 chip=3 iq=00",
                     smp_wait, smp_chip, smp_i, smp_q);
        end
        do_stop();
        pulse_start(6'd1, 10'd1023, 16'd0, 1'b0);
        next_sample();
        tests++;
        if (smp_wait != 1023 || smp_chip !== 10'd1022) begin
            fails++;
            $display("[TB] FAIL phase_clamp: got wait=%0d chip=%0d expected wait=1023 chip=1022",
                     smp_wait, smp_chip);
        end
        next_sample();
        tests++;
        if (smp_epoch !== 1'b1 || smp_chip !== 10'd0) begin
            fails++;
            $display("[TB] FAIL clamp_wrap: got epoch=%b chip=%0d expected epoch=1 chip=0",
                     smp_epoch, smp_chip);
        end
        do_stop();
    endtask

    task automatic test_epoch();
        int          n_epoch, at_epoch;
        logic [9:0]  chip_before, chip_at;
        logic [19:0] obs;
        n_epoch = 0; at_epoch = -1; chip_before = '0; chip_at = '1; obs = '0;
        pulse_start(6'd1, 10'd0, 16'd0, 1'b0);
        for (int k = 0; k < 2066; k++) begin
            next_sample();
            if (!smp_ok) break;
            if (smp_epoch) begin
                n_epoch++;
                if (at_epoch < 0) at_epoch = k;
            end
            if (k == 2044) chip_before = smp_chip;
            if (k == 2045) chip_at = smp_chip;
            if (k >= 2046) obs = {obs[18:0], smp_i};
        end
        tests++;
        if (n_epoch != 1 || at_epoch != 2045) begin
            fails++;
            $display("[TB] FAIL epoch_pulse: got count=%0d at=%0d expected count=1 at=2045",
                     n_epoch, at_epoch);
        end
        tests++;
        if (chip_before !== 10'd1022 || chip_at !== 10'd0) begin
            fails++;
            $display("[TB] FAIL epoch_chip_wrap: got %0d->%0d expected 1022->0", chip_before, chip_at);
        end
        tests++;
        if (obs !== prn1_pat) begin
            fails++;
            $display("[TB] FAIL epoch_repeat: got %b expected %b", obs, prn1_pat);
        end
        do_stop();
    endtask

    task automatic test_nav();
        int          n_epoch, at_req;
        logic [19:0] pre, post_i, post_q;
        n_epoch = 0; at_req = -1; pre = '0; post_i = '0; post_q = '0;
        bus.nav_bit = 1'b1;
        pulse_start(6'd1, 10'd0, 16'd0, 1'b1);
        for (int k = 0; k < 4112; k++) begin
            next_sample();
            if (!smp_ok) break;
            if (smp_epoch) n_epoch++;
            if (smp_nreq && at_req < 0) at_req = k;
            if (k < 20) pre = {pre[18:0], smp_i};
            if (k >= 4092) begin
                post_i = {post_i[18:0], smp_i};
                post_q = {post_q[18:0], smp_q};
            end
        end
        tests++;
        if (at_req != 4091 || n_epoch != 2) begin
            fails++;
            $display("[TB] FAIL nav_req_timing: got at=%0d epochs=%0d expected at=4091 epochs=2",
                     at_req, n_epoch);
        end
        tests++;
        if (pre !== prn1_pat) begin
            fails++;
            $display("[TB] FAIL nav_pre_bit: got %b expected %b", pre, prn1_pat);
        end
        tests++;
        if (post_i !== ~prn1_pat || post_q !== ~prn1_pat) begin
            fails++;
            $display("[TB] FAIL nav_inverted: got i=%b q=%b expected %b", post_i, post_q, ~prn1_pat);
        end
        bus.nav_bit = 1'b0;
        do_stop();
    endtask

    task automatic test_doppler();
        pulse_start(6'd1, 10'd0, 16'd16384, 1'b0);
        for (int k = 0; k < 16; k++) begin
            next_sample();
            if (!smp_ok) break;
            tests++;
            if ({smp_i, smp_q} !== exp_dop[k]) begin
                fails++;
                $display("[TB] FAIL doppler_sample%0d: got %b%b expected %b", k, smp_i, smp_q, exp_dop[k]);
            end
        end
        do_stop();
    endtask

    task automatic test_prn_err();
        logic [5:0] bad [2] = '{6'd0, 6'd33};
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            bus.prn   = bad[j];
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            tests++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL err_prn%0d: got err=%b busy=%b expected err=1 busy=0",
                         bad[j], bus.err, bus.busy);
            end
            @(negedge clk);
            tests++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL err_once_prn%0d: got err=%b busy=%b expected 0 0",
                         bad[j], bus.err, bus.busy);
            end
        end
        pulse_start(6'd32, 10'd0, 16'd0, 1'b0);
        tests++;
        if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL prn32_accept: got busy=%b err=%b expected busy=1 err=0", bus.busy, bus.err);
        end
        do_stop();
    endtask

    task automatic test_back_to_back();
        pulse_start(6'd1, 10'd0, 16'd0, 1'b0);
        next_sample();
        bus.prn   = 6'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        adc_prev  = bus.adc_clk;
        tests++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL start_while_busy: got err=%b busy=%b expected err=0 busy=1", bus.err, bus.busy);
        end
        next_sample();
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        bus.prn   = 6'd1;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        tests++;
        if (out_vec() !== 17'd0) begin
            fails++;
            $display("[TB] FAIL stop_beats_start: got %h expected 0", out_vec());
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stop_stays_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_stop_in_load();
        pulse_start(6'd1, 10'd500, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if (bus.chip_count !== 10'd3 || bus.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL load_slew: got chip=%0d busy=%b expected chip=3 busy=1",
                     bus.chip_count, bus.busy);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (out_vec() !== 17'd0) begin
            fails++;
            $display("[TB] FAIL stop_in_load: got %h expected 0", out_vec());
        end
    endtask

    task automatic test_reset_midrun();
        pulse_start(6'd1, 10'd0, 16'd0, 1'b0);
        next_sample();
        next_sample();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_vec() !== 17'd0) begin
            fails++;
            $display("[TB] FAIL reset_midrun: got %h expected 0", out_vec());
        end
        rst = 1'b1;
    endtask

    initial begin
        bus.start           = 1'b0;
        bus.stop            = 1'b0;
        bus.prn             = '0;
        bus.code_phase_init = '0;
        bus.doppler_omega   = '0;
        bus.nav_en          = 1'b0;
        bus.nav_bit         = 1'b0;
        adc_prev            = 1'b0;
        test_reset();
        test_prn1_sequence();
        test_prn2_sequence();
        test_code_phase();
        test_epoch();
        test_nav();
        test_doppler();
        test_prn_err();
        test_back_to_back();
        test_stop_in_load();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end
endmodule
